// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing the async FIFO write port among NREQ producers
module fifo_wr_arbiter #(
   parameter int NREQ      = 4,
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4,
   parameter int IDW       = $clog2(NREQ)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [NREQ-1:0]       i_req_valid,
   input  logic [NREQ*WIDTH-1:0] i_req_data,
   output logic [NREQ-1:0]       o_req_ready,
   input  logic                  i_wfull,
   output logic                  o_winc,
   output logic [WIDTH-1:0]      o_WR_Data,
   output logic                  o_grant_vld,
   output logic [IDW-1:0]        o_grant_id
);

   localparam int BW = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   owner_q, owner_d;
   logic [IDW-1:0]   last_q, last_d;
   logic [BW-1:0]    bcnt_q, bcnt_d;

   logic [IDW-1:0]   pick_base;
   logic [IDW-1:0]   pick_id;
   logic [IDW-1:0]   cand;
   logic             pick_vld;
   logic             owner_valid;
   logic [WIDTH-1:0] owner_data;
   logic             grant;
   logic             release_now;

   assign grant = (state_q == GRANT);

   // Round-robin scan starting one past the base; the base itself is visited last,
   // so on a burst-limit release the old owner only wins if nobody else is waiting.
   always_comb begin
      pick_base = grant ? owner_q : last_q;
      pick_vld  = 1'b0;
      pick_id   = '0;
      cand      = pick_base;
      for (int k = 0; k < NREQ; k++) begin
         cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + IDW'(1);
         if (!pick_vld && i_req_valid[cand]) begin
            pick_vld = 1'b1;
            pick_id  = cand;
         end
      end
   end

   // Select the current owner's valid and data lanes.
   always_comb begin
      owner_valid = 1'b0;
      owner_data  = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (owner_q == IDW'(k)) begin
            owner_valid = i_req_valid[k];
            owner_data  = i_req_data[k*WIDTH +: WIDTH];
         end
      end
   end

   // Outputs follow i_wfull combinationally; next-state handles grant, burst count and handover.
   always_comb begin
      o_req_ready = '0;
      o_winc      = 1'b0;
      o_WR_Data   = '0;
      o_grant_vld = grant;
      o_grant_id  = grant ? owner_q : '0;
      release_now = 1'b0;
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      bcnt_d      = bcnt_q;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               owner_d = pick_id;
               bcnt_d  = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            o_WR_Data = owner_data;
            if (!i_wfull) begin
               o_req_ready[owner_q] = 1'b1;
            end
            o_winc = owner_valid & !i_wfull;
            if (o_winc) begin
               bcnt_d = bcnt_q + BW'(1);
            end
            release_now = (o_winc && (bcnt_q == BW'(MAX_BURST - 1))) || !owner_valid;
            if (release_now) begin
               last_d = owner_q;
               bcnt_d = '0;
               if (pick_vld) begin
                  owner_d = pick_id;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; last starts at NREQ-1 so requester 0 has first priority after reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         owner_q <= '0;
         last_q  <= IDW'(NREQ - 1);
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         bcnt_q  <= bcnt_d;
      end
   end

endmodule
